// File: rtl/mcu_packet_scheduler_pkg.sv
// mcu_link_pkg: shared types and constants for the MCU packet link
package mcu_link_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, COOLDOWN} sched_state_t;
  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int FLAG_QUAT = 0;
  localparam int FLAG_GYRO = 1;
  localparam int SEQ_W = 8;
  localparam int PACKET_SIZE = 16;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return &v ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/mcu_packet_scheduler_if.sv
// mcu_packet_scheduler_if: sensor samples in, frozen snapshot and MCU handshake out
interface mcu_packet_scheduler_if;
  logic load, quat_valid, gyro_valid;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
  logic signed [15:0] snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z;
  logic signed [15:0] snap_gyro_x, snap_gyro_y, snap_gyro_z;
  logic snap_quat_valid, snap_gyro_valid, done, timeout_pulse;
  logic [mcu_link_pkg::SEQ_W-1:0] seq_num;
  logic [7:0] overrun_cnt;
  modport master(
    output load, quat_valid, gyro_valid, quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
    input snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z, snap_gyro_x, snap_gyro_y, snap_gyro_z,
    input snap_quat_valid, snap_gyro_valid, done, timeout_pulse, seq_num, overrun_cnt
  );
  modport slave(
    input load, quat_valid, gyro_valid, quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
    output snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z, snap_gyro_x, snap_gyro_y, snap_gyro_z,
    output snap_quat_valid, snap_gyro_valid, done, timeout_pulse, seq_num, overrun_cnt
  );
endinterface

// File: rtl/mcu_packet_scheduler_sync.sv
// sync_edge_detect: 2-flop synchronizer with rising-edge detect for MCU-side inputs
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], din};
  assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/mcu_packet_scheduler.sv
// mcu_packet_scheduler: merges sensor pulses into a frozen snapshot and runs the MCU DONE/LOAD handshake
module mcu_packet_scheduler
  import mcu_link_pkg::*;
#(
  parameter int COLLECT_CYCLES = 16,
  parameter int MIN_INTERVAL = 3000,
  parameter int ACK_TIMEOUT = 30000
) (
  input logic clk,
  input logic rst_n,
  mcu_packet_scheduler_if.slave bus
);
  localparam int MAX_A = COLLECT_CYCLES > MIN_INTERVAL ? COLLECT_CYCLES : MIN_INTERVAL;
  localparam int MAX_C = MAX_A > ACK_TIMEOUT ? MAX_A : ACK_TIMEOUT;
  localparam int CW = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] COLLECT_LD = CW'(COLLECT_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LD = CW'(MIN_INTERVAL - 1);
  localparam logic [CW-1:0] TO_LD = CW'(ACK_TIMEOUT == 0 ? 0 : ACK_TIMEOUT - 1);
  sched_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0][15:0] quat_q, quat_d;
  logic [2:0][15:0] gyro_q, gyro_d;
  logic [1:0] flags_q, flags_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [7:0] ovr_q, ovr_d;
  logic done_q, done_d, tmo_q, tmo_d;
  logic load_edge, any_v, cap;
  sync_edge_detect u_load_sync (.clk(clk), .rst_n(rst_n), .din(bus.load), .rise(load_edge));
  assign any_v = bus.quat_valid | bus.gyro_valid;
  assign cap = state_q != PRESENT;
  always_comb begin
    quat_d = cap && bus.quat_valid ? {bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z} : quat_q;
    gyro_d = cap && bus.gyro_valid ? {bus.gyro_x, bus.gyro_y, bus.gyro_z} : gyro_q;
    flags_d = flags_q;
    flags_d[FLAG_QUAT] = flags_q[FLAG_QUAT] | (cap & bus.quat_valid);
    flags_d[FLAG_GYRO] = flags_q[FLAG_GYRO] | (cap & bus.gyro_valid);
    ovr_d = !cap && any_v ? sat_inc(ovr_q) : ovr_q;
    state_d = state_q;
    cnt_d = cnt_q;
    seq_d = seq_q;
    tmo_d = 1'b0;
    case (state_q)
      IDLE: if (any_v) begin
        state_d = COLLECT;
        cnt_d = COLLECT_LD;
      end
      COLLECT: if (cnt_q == '0) begin
        state_d = PRESENT;
        cnt_d = TO_LD;
      end else cnt_d = cnt_q - CW'(1);
      // an ack arriving on the timeout cycle wins over the timeout
      PRESENT: if (load_edge) begin
        state_d = COOLDOWN;
        seq_d = seq_q + SEQ_W'(1);
        flags_d = '0;
        cnt_d = COOL_LD;
      end else if (ACK_TIMEOUT != 0 && cnt_q == '0) begin
        state_d = COOLDOWN;
        tmo_d = 1'b1;
        flags_d = '0;
        cnt_d = COOL_LD;
      end else if (ACK_TIMEOUT != 0) cnt_d = cnt_q - CW'(1);
      COOLDOWN: if (cnt_q == '0) begin
        state_d = |flags_d ? COLLECT : IDLE;
        cnt_d = COLLECT_LD;
      end else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
    done_d = state_d == PRESENT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      quat_q <= '0;
      gyro_q <= '0;
      flags_q <= '0;
      seq_q <= '0;
      ovr_q <= '0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      quat_q <= quat_d;
      gyro_q <= gyro_d;
      flags_q <= flags_d;
      seq_q <= seq_d;
      ovr_q <= ovr_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
    end
  assign bus.snap_quat_w = quat_q[3];
  assign bus.snap_quat_x = quat_q[2];
  assign bus.snap_quat_y = quat_q[1];
  assign bus.snap_quat_z = quat_q[0];
  assign bus.snap_gyro_x = gyro_q[2];
  assign bus.snap_gyro_y = gyro_q[1];
  assign bus.snap_gyro_z = gyro_q[0];
  assign bus.snap_quat_valid = flags_q[FLAG_QUAT];
  assign bus.snap_gyro_valid = flags_q[FLAG_GYRO];
  assign bus.done = done_q;
  assign bus.seq_num = seq_q;
  assign bus.overrun_cnt = ovr_q;
  assign bus.timeout_pulse = tmo_q;
endmodule
